// File: rtl/uart_pkg.sv
// Shared UART definitions: divider floor, frame width and the receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_DIV_MIN   = 4;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Anything below the floor would leave no room for a mid-bit sample point.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < UART_DIV_MIN) ? 32'(UART_DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign rd_valid = (level != '0);
  assign full     = (level == FULL_LEVEL);
  assign do_pop   = rd_valid && rd_ready;
  assign do_push  = wr_en && (!full || do_pop);
  // Head is forced to zero while empty so stale entries never leak out.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, programmable divider, sticky error
// flags and a show-ahead receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DIV_RESET  = 106,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ser_rx,
  input  logic                          cfg_div_we,
  input  logic [31:0]                   cfg_div_wdata,
  output logic [31:0]                   cfg_div,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clear,
  output rx_state_e                     dbg_state
);

  logic                      sync1;
  logic                      rxs;
  logic [31:0]               div_l;
  logic [31:0]               cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  rx_state_e                 state;

  logic stop_hit;
  logic push;
  logic fe_set;
  logic fifo_full;
  logic drop;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_div <= 32'(DIV_RESET);
    else if (cfg_div_we) cfg_div <= clamp_div(cfg_div_wdata);
  end

  // Stop-bit decision is decoded from registered state so the byte lands in
  // the FIFO on the same edge the FSM returns to IDLE.
  assign stop_hit = (state == STOP) && (cnt == '0);
  assign push     = stop_hit && rxs;
  assign fe_set   = stop_hit && !rxs;
  assign drop     = push && fifo_full && !(rx_valid && rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div_l   <= 32'(DIV_RESET);
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            div_l <= cfg_div;
            cnt   <= (cfg_div >> 1) - 32'd1;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 32'd1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            cnt     <= div_l - 32'd1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 32'd1;
          end else begin
            shreg   <= {rxs, shreg[UART_DATA_BITS-1:1]};
            cnt     <= div_l - 32'd1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - 32'd1;
          else state <= rxs ? IDLE : BREAK;
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (fe_set)         frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (drop)           overrun   <= 1'b1;
      else if (err_clear) overrun   <= 1'b0;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (shreg),
    .full     (fifo_full),
    .rd_valid (rx_valid),
    .rd_ready (rx_ready),
    .rd_data  (rx_data),
    .level    (rx_level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table-driven byte vectors plus hand-timed
// sequences for overrun, framing, glitch, divider change and reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DIV = 106;
  localparam int HALF = DIV / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_rx = 1'b1;
  logic        cfg_div_we = 1'b0;
  logic [31:0] cfg_div_wdata = '0;
  logic [31:0] cfg_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  rx_level;
  logic        frame_err;
  logic        overrun;
  logic        err_clear = 1'b0;
  rx_state_e   dbg_state;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] tx;
    int         div;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[4];

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .ser_rx        (ser_rx),
    .cfg_div_we    (cfg_div_we),
    .cfg_div_wdata (cfg_div_wdata),
    .cfg_div       (cfg_div),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_level      (rx_level),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .err_clear     (err_clear),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one frame starting at the current negedge; line is left at the stop level.
  task automatic send_byte(input logic [7:0] b, input int div, input logic stop);
    ser_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (div) @(negedge clk);
    end
    ser_rx = stop;
    repeat (div) @(negedge clk);
  endtask

  task automatic write_div(input logic [31:0] v);
    cfg_div_we    = 1'b1;
    cfg_div_wdata = v;
    @(negedge clk);
    cfg_div_we    = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(rx_valid), 32'd1);
    check({name, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) pop_check(name, exp_q.pop_front());
    check({name, "_empty"}, 32'(rx_level), 32'd0);
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{tx: 8'h55, div: DIV, exp: 8'h55};
    vecs[1] = '{tx: 8'hA3, div: DIV, exp: 8'hA3};
    vecs[2] = '{tx: 8'h00, div: DIV, exp: 8'h00};
    vecs[3] = '{tx: 8'hFF, div: DIV, exp: 8'hFF};

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_level", 32'(rx_level), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_fe", 32'(frame_err), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_div", cfg_div, 32'd106);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Table-driven bytes, consumer stalled, then ordered drain.
    for (int i = 0; i < 4; i++) send_byte(vecs[i].tx, vecs[i].div, 1'b1);
    check("t1_level", 32'(rx_level), 32'd4);
    check("t1_fe", 32'(frame_err), 32'd0);
    check("t1_ov", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("t1_pop", vecs[i].exp);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    check("t1_underflow_level", 32'(rx_level), 32'd0);
    check("t1_underflow_valid", 32'(rx_valid), 32'd0);

    // Ten back-to-back bytes into an 8-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'(i * 29 + 7);
      if (i < 8) exp_q.push_back(b);
      send_byte(b, DIV, 1'b1);
    end
    check("t2_level", 32'(rx_level), 32'd8);
    check("t2_ov", 32'(overrun), 32'd1);
    check("t2_head", 32'(rx_data), 32'(exp_q[0]));
    pulse_err_clear();
    check("t2_ov_clear", 32'(overrun), 32'd0);
    drain("t2_drain");

    // Full FIFO, pop lands exactly in the stop-sample cycle of the ninth byte.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(8'hC0 + i);
      exp_q.push_back(b);
      send_byte(b, DIV, 1'b1);
    end
    check("t2b_full", 32'(rx_level), 32'd8);
    fork
      send_byte(8'h3E, DIV, 1'b1);
      begin
        repeat (2 + HALF + 9 * DIV) @(negedge clk);
        check("t2b_head", 32'(rx_data), 32'(exp_q.pop_front()));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    exp_q.push_back(8'h3E);
    check("t2b_level", 32'(rx_level), 32'd8);
    check("t2b_ov", 32'(overrun), 32'd0);
    drain("t2b_drain");

    // Stop bit low, line held in break, then recovery.
    do_reset();
    send_byte(8'h3C, DIV, 1'b0);
    repeat (30 * DIV) @(negedge clk);
    check("t3_fe", 32'(frame_err), 32'd1);
    check("t3_level", 32'(rx_level), 32'd0);
    check("t3_state", 32'(dbg_state), 32'(BREAK));
    ser_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("t3_idle", 32'(dbg_state), 32'(IDLE));
    send_byte(8'h41, DIV, 1'b1);
    check("t3_level2", 32'(rx_level), 32'd1);
    pop_check("t3_pop", 8'h41);
    check("t3_fe_sticky", 32'(frame_err), 32'd1);
    pulse_err_clear();
    check("t3_fe_clear", 32'(frame_err), 32'd0);

    // 20-cycle glitch is rejected at the start-bit sample.
    do_reset();
    ser_rx = 1'b0;
    repeat (20) @(negedge clk);
    ser_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_start", 32'(dbg_state), 32'(START));
    repeat (30) @(negedge clk);
    check("t4_idle", 32'(dbg_state), 32'(IDLE));
    repeat (DIV * 10) @(negedge clk);
    check("t4_level", 32'(rx_level), 32'd0);
    write_div(32'd2);
    check("t4_div_min", cfg_div, 32'd4);
    write_div(32'd5);
    check("t4_div_5", cfg_div, 32'd5);

    // Divider change mid-frame only affects the following frame.
    do_reset();
    fork
      send_byte(8'hA5, DIV, 1'b1);
      begin
        repeat (300) @(negedge clk);
        write_div(32'd20);
      end
    join
    check("t5_div", cfg_div, 32'd20);
    pop_check("t5_pop_old", 8'hA5);
    send_byte(8'h7E, 20, 1'b1);
    check("t5_level", 32'(rx_level), 32'd1);
    pop_check("t5_pop_new", 8'h7E);

    // Reset during data bit 4 wipes the FIFO and the partial frame.
    do_reset();
    send_byte(8'h5A, DIV, 1'b1);
    check("t6_pre_level", 32'(rx_level), 32'd1);
    fork
      send_byte(8'hF2, DIV, 1'b1);
      begin
        repeat (5 * DIV + 50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(rx_valid), 32'd0);
        check("t6_level", 32'(rx_level), 32'd0);
        check("t6_data", 32'(rx_data), 32'd0);
        check("t6_state", 32'(dbg_state), 32'(IDLE));
        check("t6_div", cfg_div, 32'd106);
      end
    join
    check("t6_no_partial", 32'(rx_level), 32'd0);
    send_byte(8'h81, DIV, 1'b1);
    pop_check("t6_pop", 8'h81);
    check("t6_fe", 32'(frame_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable 8N1 UART receiver with a small receive FIFO.
- Sits in the SoC between the ser_rx pad and the CPU-facing UART register block.
- Oversamples the line with a programmable cycles-per-bit divider and samples each bit at mid-point.
- Delivers bytes through a show-ahead valid/ready port, with sticky frame-error and overrun flags.

Parameters:
- DIV_RESET, 106, cycles per bit after reset (matches the simulation serial bit time of 2x53 clocks).
- FIFO_DEPTH, 8, receive FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ser_rx  in  1  asynchronous serial input; idle high
- cfg_div_we  in  1  divider write strobe
- cfg_div_wdata  in  32  new cycles-per-bit value
- cfg_div  out  32  current divider value
- rx_data  out  8  FIFO head byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pops the head when rx_valid is high
- rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- frame_err  out  1  sticky: a stop bit was sampled low
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- err_clear  in  1  clears frame_err and overrun

Behaviour:
- Reset values:
  - cfg_div = DIV_RESET.
  - rx_valid = 0, rx_level = 0, rx_data = 0.
  - frame_err = 0, overrun = 0.
  - Synchronizer flops = 1.
  - FSM in IDLE, bit counter 0.
- Input path: 2-flop synchronizer on ser_rx; the FSM uses only the second flop (rxs). Latency from pin to rxs is 2 clk.
- Divider:
  - A cfg_div_we write stores max(cfg_div_wdata, 4).
  - The receiver latches the divider into an internal working copy (div_l) on start detection. A write during a frame therefore takes effect on the next frame.
  - half = div_l >> 1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs==0 -> latch div_l, load the counter with half-1, go to START.
  - START: count down to 0, then sample rxs.
    - rxs==1 (glitch) -> IDLE, nothing recorded.
    - rxs==0 -> reload the counter with div_l-1, bit index 0, go to DATA.
  - DATA: at counter 0, shift rxs into bit[7] of the shift register (LSB first); reload the counter with div_l-1. After bit index 7 is sampled, go to STOP.
  - STOP: at counter 0, sample rxs.
    - rxs==1: push the byte and go to IDLE in the same cycle. The next start bit may therefore begin half a bit later.
    - rxs==0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE.
- Sample timing relative to the cycle IDLE sees rxs==0:
  - start bit sampled at +half
  - data bit k sampled at +half+(k+1)*div_l
  - stop bit sampled at +half+9*div_l
- FIFO:
  - Show-ahead: rx_data is the head entry and is valid whenever rx_valid = (rx_level != 0).
  - Pop when rx_valid && rx_ready.
  - Push is visible on rx_valid and rx_level the cycle after the stop sample.
- Pointers wrap modulo FIFO_DEPTH.
- Push while full with no pop: drop the new byte, set overrun; FIFO contents unchanged.
- Push while full with a pop in the same cycle: the push is accepted and rx_level stays FIFO_DEPTH; no overrun.
- Push and pop while empty: no bypass; the byte appears the next cycle.
- Pop while empty: ignored; rx_level never underflows.
- err_clear: clears both sticky flags on the next edge. If err_clear and a new error occur in the same cycle, the flag stays set (set wins).
- rst asserted mid-frame or mid-FIFO: immediate return to reset values; the partial byte and FIFO contents are lost.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DIV_MIN = 4
  - UART_DATA_BITS = 8
  - the rx state enum (IDLE, START, DATA, STOP, BREAK)
- Sub-module sync_fifo: parameterized DEPTH/WIDTH, show-ahead, with level output and the full-with-pop accept rule above. Reused later by the UART TX path.

Test Plan:
- Bytes 0x55, 0xA3, 0x00, 0xFF at div 106, with a consumer holding rx_ready=0 -> rx_level=4. Popping yields 0x55, 0xA3, 0x00, 0xFF in order; frame_err=0, overrun=0.
- 10 back-to-back bytes with the stop bit exactly 1 bit long, FIFO_DEPTH=8, rx_ready=0 -> 8 bytes stored, overrun=1, head is still byte 0. Repeat with a pop in the stop-sample cycle while full -> accepted, no overrun.
- 0x3C sent with the stop bit held low, the line then held low for 30 bits -> frame_err=1, rx_level unchanged, FSM in BREAK. Line high, then 0x41 -> 0x41 received. err_clear -> frame_err=0.
- 20-cycle low glitch at div 106 -> no byte, FSM back in IDLE after half=53 cycles. cfg_div written with 2 -> reads back 4.
- cfg_div written to 20 mid-frame -> the current byte is decoded at 106. The next byte, sent at 20 cycles/bit, receives 0x7E.
- rst pulsed after the 4th data bit of a frame -> all outputs at reset values. The following clean byte 0x81 is received correctly.
